// File: rtl/lsu_mem_initiator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator_if
// Purpose  : Core-side request/response and data-memory bus bundle for the
//            load/store unit. The master modport is the LSU view; the slave
//            modport is the view of whatever sits around it (core + memory).
// Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_initiator_if;
  // core request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // core response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  // data memory bus
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Purpose  : Multi-cycle RV32I load/store unit. Takes one request from the
//            core, validates funct3/alignment, issues a word-aligned memory
//            access with byte strobes, extends load data and returns a
//            single-cycle response with an error code.
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_initiator #(
  parameter int TIMEOUT = 16
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  lsu_mem_initiator_if.master bus
);

  localparam int C_CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] C_ERR_OK    = 2'b00;
  localparam logic [1:0] C_ERR_ALIGN = 2'b01;
  localparam logic [1:0] C_ERR_F3    = 2'b10;
  localparam logic [1:0] C_ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_write;
  logic [2:0]           r_funct3;
  logic [1:0]           r_off;
  logic [31:0]          r_wdata;
  logic [29:0]          r_waddr;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_resp_rdata;
  logic [1:0]           r_resp_err;

  logic                 w_illegal;
  logic                 w_misalign;
  logic                 w_tmo_hit;
  logic                 w_set_resp;
  logic [1:0]           w_resp_err;
  logic [31:0]          w_resp_rdata;
  logic [7:0]           w_ld_byte;
  logic [15:0]          w_ld_half;
  logic [31:0]          w_ld_data;
  logic [3:0]           w_wstrb;
  logic [31:0]          w_wdata;
  logic                 w_mem_valid;

  // Decode the incoming request; only meaningful while IDLE with req_valid.
  always_comb begin
    if (bus.req_write) begin
      w_illegal = (bus.req_funct3 > 3'd2);
    end else begin
      w_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 > 3'd5);
    end
    // funct3[1:0] encodes access size for every legal load/store
    w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

  assign w_tmo_hit = (r_cnt == C_CNT_W'(TIMEOUT - 1));

  // Pick the addressed byte/half of the returned word and extend it.
  always_comb begin
    w_ld_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
    w_ld_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3)
      3'd0:    w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'd1:    w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'd4:    w_ld_data = {24'd0, w_ld_byte};
      3'd5:    w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = bus.mem_rdata;
    endcase
  end

  // Store lane strobes and lane-replicated data from the latched request.
  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << r_off;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << r_off;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'hF;
        w_wdata = r_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and the response value loaded when entering RESP.
  always_comb begin
    w_next       = r_state;
    w_set_resp   = 1'b0;
    w_resp_err   = C_ERR_OK;
    w_resp_rdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_illegal) begin
            w_next     = S_RESP;
            w_set_resp = 1'b1;
            w_resp_err = C_ERR_F3;
          end else if (w_misalign) begin
            w_next     = S_RESP;
            w_set_resp = 1'b1;
            w_resp_err = C_ERR_ALIGN;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        // acceptance beats a timeout landing in the same cycle
        if (bus.mem_ready) begin
          if (r_write) begin
            w_next     = S_RESP;
            w_set_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end else if (w_tmo_hit) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_resp_err = C_ERR_TMO;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          w_next       = S_RESP;
          w_set_resp   = 1'b1;
          w_resp_rdata = w_ld_data;
        end else if (w_tmo_hit) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_resp_err = C_ERR_TMO;
        end
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request, run the timeout counter and register the response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_write      <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_wdata      <= 32'd0;
      r_waddr      <= 30'd0;
      r_cnt        <= '0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 2'b00;
    end else begin
      if ((r_state == S_IDLE) && bus.req_valid) begin
        r_write  <= bus.req_write;
        r_funct3 <= bus.req_funct3;
        r_off    <= bus.req_addr[1:0];
        r_wdata  <= bus.req_wdata;
        r_waddr  <= bus.req_addr[31:2];
      end
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // response fields read zero outside the single RESP cycle
      r_resp_rdata <= w_set_resp ? w_resp_rdata : 32'd0;
      r_resp_err   <= w_set_resp ? w_resp_err : 2'b00;
    end
  end

  assign w_mem_valid    = (r_state == S_REQ);
  assign bus.mem_valid  = w_mem_valid;
  assign bus.mem_write  = w_mem_valid & r_write;
  assign bus.mem_addr   = w_mem_valid ? {r_waddr, 2'b00} : 32'd0;
  assign bus.mem_wstrb  = (w_mem_valid && r_write) ? w_wstrb : 4'd0;
  assign bus.mem_wdata  = (w_mem_valid && r_write) ? w_wdata : 32'd0;
  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Purpose  : Self-checking bench for lsu_mem_initiator: directed cases plus
//            randomized transactions against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_initiator;

  localparam int TO = 16;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  lsu_mem_initiator_if bus ();

  lsu_mem_initiator #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural result of one request, from size/offset arithmetic.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       output logic [1:0] err, output logic [31:0] ld,
                       output logic [3:0] strb, output logic [31:0] wd);
    int   nbytes;
    int   off;
    bit   legal;
    logic [31:0] raw;
    off    = int'(addr % 4);
    legal  = wr ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
    nbytes = 1 << (f3 % 4);
    if (!legal)                 err = 2'd2;
    else if (addr % nbytes != 0) err = 2'd1;
    else                        err = 2'd0;
    ld = 32'd0; strb = 4'd0; wd = 32'd0;
    if (err == 2'd0 && wr) begin
      strb = 4'(((1 << nbytes) - 1) << off);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
    if (err == 2'd0 && !wr) begin
      raw = rdata >> (8 * off);
      if (nbytes < 4) begin
        raw = raw & 32'((64'd1 << (8 * nbytes)) - 1);
        if (f3 < 3'd4 && raw[8*nbytes-1]) raw = raw - 32'(64'd1 << (8 * nbytes));
      end
      ld = raw;
    end
  endtask

  // Issue one request at cycle 0 and act as memory: ready after rdy_dly
  // cycles of mem_valid, read data rv_dly cycles after acceptance (<0: never).
  task automatic run_txn(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
    logic [1:0]  e_err;
    logic [31:0] e_ld, e_wd;
    logic [3:0]  e_strb;
    int e_cyc, e_mv, exitc;
    int vcnt, acc, rcyc, mvfirst;
    logic [1:0]  o_err;
    logic [31:0] o_ld;
    bit fields_ok;
    model(wr, f3, addr, wdata, rdata, e_err, e_ld, e_strb, e_wd);
    if (e_err != 2'd0) begin
      e_cyc = 1; e_mv = 0;
    end else begin
      exitc = wr ? (1 + rdy_dly) : ((rv_dly < 0) ? 1000 : (1 + rdy_dly + rv_dly));
      if (exitc > TO) begin
        e_cyc = TO + 1; e_err = 2'd3; e_ld = 32'd0;
        e_mv  = (1 + rdy_dly > TO) ? TO : rdy_dly + 1;
      end else begin
        e_cyc = exitc + 1; e_mv = rdy_dly + 1;
      end
    end
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, ".idle_resp"}, {bus.resp_rdata[29:0], bus.resp_err}, 32'd0);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_rdata  = rdata;
    vcnt = 0; acc = -1; rcyc = -1; mvfirst = -1; fields_ok = 1'b1;
    o_err = 2'd0; o_ld = 32'd0;
    for (int c = 1; c <= 60 && rcyc < 0; c++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.mem_ready  = 1'b0;
      // stores see a stray rvalid, which must have no effect
      bus.mem_rvalid = wr;
      if (bus.mem_valid) begin
        if (mvfirst < 0) mvfirst = c;
        if (bus.mem_addr !== {addr[31:2], 2'b00} || bus.mem_write !== wr ||
            bus.mem_wstrb !== e_strb || (wr && bus.mem_wdata !== e_wd)) fields_ok = 1'b0;
        if (vcnt >= rdy_dly) begin
          bus.mem_ready = 1'b1;
          acc = c;
        end
        vcnt++;
      end
      if (!wr && acc >= 0 && rv_dly >= 0 && c == acc + rv_dly) bus.mem_rvalid = 1'b1;
      if (bus.resp_valid) begin
        rcyc  = c;
        o_err = bus.resp_err;
        o_ld  = bus.resp_rdata;
      end
    end
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    check({tag, ".resp_cycle"}, 32'(rcyc), 32'(e_cyc));
    check({tag, ".err"}, 32'(o_err), 32'(e_err));
    check({tag, ".rdata"}, o_ld, e_ld);
    check({tag, ".mv_first"}, 32'(mvfirst), (e_mv > 0) ? 32'd1 : 32'hFFFF_FFFF);
    check({tag, ".mv_cycles"}, 32'(vcnt), 32'(e_mv));
    check({tag, ".mem_fields"}, 32'(fields_ok), 32'd1);
  endtask

  initial begin
    bit quiet;
    total = 0; bad = 0;
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset.req_ready", 32'(bus.req_ready), 32'd1);
    check("reset.mem_valid", 32'(bus.mem_valid), 32'd0);
    check("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset.mem_bus", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_wstrb), 32'd0);
    rstn = 1'b1;

    // directed cases
    run_txn("lb",      1'b0, 3'd0, 32'h0000_0103, 32'd0,         32'h80FF_0000, 0, 1);
    run_txn("lhu",     1'b0, 3'd5, 32'h0000_0202, 32'd0,         32'h9ABC_1234, 0, 1);
    run_txn("lh",      1'b0, 3'd1, 32'h0000_0202, 32'd0,         32'h9ABC_1234, 0, 1);
    run_txn("sh",      1'b1, 3'd1, 32'h0000_0302, 32'hDEAD_BEEF, 32'd0,         3, 1);
    run_txn("lw_mis",  1'b0, 3'd2, 32'h0000_0101, 32'd0,         32'h1234_5678, 0, 1);
    run_txn("ld_f3",   1'b0, 3'd3, 32'h0000_0100, 32'd0,         32'h1234_5678, 0, 1);
    run_txn("st_f3",   1'b1, 3'd4, 32'h0000_0100, 32'h1111_2222, 32'd0,         0, 1);
    run_txn("sb",      1'b1, 3'd0, 32'h0000_0501, 32'h0000_00A5, 32'd0,         0, 1);
    run_txn("tmo",     1'b0, 3'd2, 32'h0000_0400, 32'd0,         32'hCAFE_F00D, 0, -1);
    run_txn("tmo_edge",1'b0, 3'd2, 32'h0000_0400, 32'd0,         32'hCAFE_F00D, 0, TO - 1);
    run_txn("st_tmo",  1'b1, 3'd2, 32'h0000_0600, 32'h0BAD_F00D, 32'd0,         TO + 2, 1);

    // reset while waiting for read data
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h0000_0800;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_wait.mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_wait.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_wait.resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (bus.resp_valid || bus.mem_valid) quiet = 1'b0;
    end
    check("late_rvalid.quiet", 32'(quiet), 32'd1);
    run_txn("sw_after_rst", 1'b1, 3'd2, 32'h0000_0900, 32'h1357_9BDF, 32'd0, 1, 1);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [2:0]  f3;
      int          rdy, rv;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (wr) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 3));
          if (f3 == 3'd3) f3 = 3'($urandom_range(4, 5));
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      rdy = $urandom_range(0, 3);
      rv  = $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) rdy = $urandom_range(10, 18);
      run_txn("rand", wr, f3, $urandom, $urandom, $urandom, rdy, rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Multi-cycle load/store unit for the mini CPU: the initiator on the data memory bus, the opposite end of the data_memory responder.
- Accepts one RV32I load/store from the core via valid/ready.
- Checks alignment and funct3, then issues a word-aligned memory request with byte strobes.
- Extracts and sign/zero-extends load data, and returns a single-cycle response with an error code.

Parameters:
- TIMEOUT, 16, max cycles spent in REQ+WAIT before aborting with a timeout error (>=2).

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous reset, active low
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request (IDLE only)
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_write  out  1  memory write enable
- mem_addr  out  32  word address, bits [1:0]=0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes; 0 for loads
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (async, rstn=0): state=IDLE; all outputs 0 except req_ready=1; timeout counter=0; any transaction in flight is abandoned with no response.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr[1:0] offset, wdata and word address.
  - Legal funct3: loads 0,1,2,4,5; stores 0,1,2.
  - Illegal funct3 -> RESP with err=10.
  - Illegal funct3 takes priority over misaligned.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> RESP with err=01.
  - Any error path makes no memory access.
  - Otherwise -> REQ.
- REQ: mem_valid=1; mem_addr, mem_write, mem_wdata and mem_wstrb are held stable until mem_ready.
  - On mem_ready, a store goes to RESP (write completes on acceptance) and a load goes to WAIT.
- Store strobes: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'hF.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- WAIT: on mem_rvalid, select the byte/half at the latched offset and extend it.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Then -> RESP.
  - mem_rvalid outside WAIT is ignored.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - If it reaches TIMEOUT-1 without the exiting event (mem_ready in REQ, or mem_rvalid in WAIT): -> RESP, err=11, rdata=0, mem_valid drops.
  - If the exiting event arrives in that same cycle, it wins.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata/resp_err are registered and valid only while resp_valid=1, 0 otherwise; next state IDLE.
  - No response backpressure.
  - req_ready=0 in REQ, WAIT and RESP, so at most one request is outstanding.
- Latency (request accepted at cycle 0, zero-wait memory):
  - mem_valid at cycle 1.
  - Store resp at cycle 2.
  - Load with mem_rvalid at cycle 2: resp at cycle 3.
  - Error resp at cycle 1.
- Back-to-back: next request accepted in the cycle after resp_valid.

Test Plan:
- LB addr=0x103, mem_rdata=0x80FF_0000, one-cycle memory -> mem_addr=0x100, mem_wstrb=0, resp_rdata=0xFFFF_FF80, err=00, resp at cycle 3.
- LHU addr=0x202, mem_rdata=0x9ABC_1234 -> resp_rdata=0x0000_9ABC.
- LH addr=0x202, same data -> resp_rdata=0xFFFF_9ABC.
- SH addr=0x302, wdata=0xDEAD_BEEF, mem_ready after 3 wait cycles -> mem_valid held 4 cycles, wstrb=4'b1100, mem_wdata=0xBEEF_BEEF, mem_write=1, resp at acceptance+1, err=00.
- LW addr=0x101 -> err=01 at cycle 1, mem_valid never asserted.
- Load funct3=3 -> err=10 at cycle 1, mem_valid never asserted.
- Store funct3=4 -> err=10.
- TIMEOUT=16 load, mem_ready=1 but mem_rvalid held 0 -> resp_valid 16 cycles after REQ entry, err=11, rdata=0.
- Same, but mem_rvalid arrives on the last cycle -> err=00.
- rstn pulsed low while in WAIT -> outputs immediately 0, req_ready=1, no resp_valid.
- A late mem_rvalid after the reset is ignored.
- A new SW then completes normally.
